obi_hetic_arb: RTL

Parametrised successor interrupt controller (HETI-capable). It holds per-line config/status registers behind an OBI subordinate port and samples external interrupt lines with per-line trigger mode. It arbitrates pending+enabled lines by priority against a global threshold and presents one registered winner to the core, with an ID-based claim/ack handshake. It sits between peripheral IRQ sources and the core's interrupt interface.

---
 rtl/hetic_pkg.sv | 21 ++
 rtl/obi_bus_if.sv | 17 +
 rtl/hetic_arb_tree.sv | 51 +++++
 rtl/obi_hetic_arb.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/hetic_pkg.sv
// Shared types and register-map constants for the HETI-capable interrupt controller.
package hetic_pkg;

    typedef enum logic [1:0] {
        TRIG_LEVEL_HI = 2'b00,
        TRIG_RISE     = 2'b01,
        TRIG_FALL     = 2'b10,
        TRIG_LEVEL_LO = 2'b11
    } trig_e;

    localparam int unsigned IE_BIT    = 0;
    localparam int unsigned IP_BIT    = 1;
    localparam int unsigned TRIG_LSB  = 2;
    localparam int unsigned HETI_BIT  = 4;
    localparam int unsigned NEST_BIT  = 5;
    localparam int unsigned PRIO_LSB  = 8;
    localparam int unsigned LINE_BITS = 16;

    localparam logic [31:0] THRESH_ADDR = 32'h0000_0FFC;

endpackage

// File: rtl/obi_bus_if.sv
// Minimal OBI request/response bundle used for register access.
interface OBI_BUS #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    logic                   req;
    logic                   gnt;
    logic [AddrWidth-1:0]   addr;
    logic                   we;
    logic [DataWidth/8-1:0] be;
    logic [DataWidth-1:0]   wdata;
    logic                   rvalid;
    logic [DataWidth-1:0]   rdata;

    modport Manager (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport Subordinate (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/hetic_arb_tree.sv
// Combinational max-priority compare tree; on equal priority the lower line index wins.
module hetic_arb_tree #(
    parameter int unsigned NrIrqLines = 64,
    parameter int unsigned PrioWidth  = 5,
    localparam int unsigned IrqWidth  = $clog2(NrIrqLines)
) (
    input  logic [NrIrqLines-1:0]           cand_valid,
    input  logic [NrIrqLines*PrioWidth-1:0] cand_prio,
    output logic                            win_valid,
    output logic [PrioWidth-1:0]            win_prio,
    output logic [IrqWidth-1:0]             win_id
);

    localparam int unsigned Levels = IrqWidth;

    for (genvar l = 0; l <= Levels; l++) begin : g_lvl
        localparam int unsigned Width = 2 ** (Levels - l);
        logic [Width-1:0]                vld;
        logic [Width-1:0][PrioWidth-1:0] prio;
        logic [Width-1:0][IrqWidth-1:0]  id;

        if (l == 0) begin : g_leaf
            // Leaves are padded to a power of two with never-valid entries.
            for (genvar j = 0; j < Width; j++) begin : g_node
                if (j < NrIrqLines) begin : g_real
                    assign vld[j]  = cand_valid[j];
                    assign prio[j] = cand_prio[j*PrioWidth +: PrioWidth];
                end else begin : g_pad
                    assign vld[j]  = 1'b0;
                    assign prio[j] = '0;
                end
                assign id[j] = IrqWidth'(j);
            end
        end else begin : g_cmp
            for (genvar j = 0; j < Width; j++) begin : g_node
                logic take_right;
                assign take_right = g_lvl[l-1].vld[2*j+1] &&
                                    (!g_lvl[l-1].vld[2*j] ||
                                     (g_lvl[l-1].prio[2*j+1] > g_lvl[l-1].prio[2*j]));
                assign vld[j]  = g_lvl[l-1].vld[2*j] | g_lvl[l-1].vld[2*j+1];
                assign prio[j] = take_right ? g_lvl[l-1].prio[2*j+1] : g_lvl[l-1].prio[2*j];
                assign id[j]   = take_right ? g_lvl[l-1].id[2*j+1]   : g_lvl[l-1].id[2*j];
            end
        end
    end

    assign win_valid = g_lvl[Levels].vld[0];
    assign win_prio  = g_lvl[Levels].prio[0];
    assign win_id    = g_lvl[Levels].id[0];

endmodule

// File: rtl/obi_hetic_arb.sv
// Interrupt controller: per-line config/status behind OBI, trigger sampling,
// priority arbitration against a threshold and a registered winner with claim/ack.
module obi_hetic_arb
    import hetic_pkg::*;
#(
    parameter int unsigned NrIrqLines = 64,
    parameter int unsigned NrIrqPrios = 32,
    localparam int unsigned IrqWidth  = $clog2(NrIrqLines),
    localparam int unsigned PrioWidth = $clog2(NrIrqPrios)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    OBI_BUS.Subordinate           obi_sbr,
    input  logic [NrIrqLines-1:0] irq_i,
    output logic                  irq_valid_o,
    output logic                  irq_heti_o,
    output logic                  irq_nest_o,
    output logic [IrqWidth-1:0]   irq_id_o,
    output logic [PrioWidth-1:0]  irq_prio_o,
    input  logic [IrqWidth-1:0]   irq_id_i,
    input  logic                  irq_ack_i
);

    typedef struct packed {
        logic [PrioWidth-1:0] prio;
        logic                 nest;
        logic                 heti;
        trig_e                trig;
        logic                 ip;
        logic                 ie;
    } irq_line_t;

    localparam int unsigned NrWords    = NrIrqLines / 2;
    localparam logic [29:0] ThreshWord = THRESH_ADDR[31:2];

    irq_line_t               line_q [NrIrqLines];
    irq_line_t               line_d [NrIrqLines];
    logic [PrioWidth-1:0]    thresh_q, thresh_d;
    logic [NrIrqLines-1:0]   irq_q;

    logic [29:0]             word_idx;
    logic                    thresh_hit, line_hit, wr_en, rd_en;
    logic [31:0]             rd_word;
    logic                    rvalid_q;
    logic [31:0]             rdata_q;

    logic [NrIrqLines-1:0]           cand_valid;
    logic [NrIrqLines*PrioWidth-1:0] cand_prio;
    logic                            win_valid;
    logic [PrioWidth-1:0]            win_prio;
    logic [IrqWidth-1:0]             win_id;

    logic [31:0]             unused_wdata;
    logic [1:0]              unused_addr;

    function automatic logic [LINE_BITS-1:0] pack_line(irq_line_t line);
        logic [LINE_BITS-1:0] bits;
        bits                        = '0;
        bits[IE_BIT]                = line.ie;
        bits[IP_BIT]                = line.ip;
        bits[TRIG_LSB +: 2]         = line.trig;
        bits[HETI_BIT]              = line.heti;
        bits[NEST_BIT]              = line.nest;
        bits[PRIO_LSB +: PrioWidth] = line.prio;
        return bits;
    endfunction

    assign word_idx     = obi_sbr.addr[31:2];
    assign unused_addr  = obi_sbr.addr[1:0];
    assign unused_wdata = obi_sbr.wdata;
    assign thresh_hit   = (word_idx == ThreshWord);
    assign line_hit     = !thresh_hit && (word_idx < 30'(NrWords));
    assign wr_en        = obi_sbr.req && obi_sbr.we;
    assign rd_en        = obi_sbr.req && !obi_sbr.we;

    assign obi_sbr.gnt    = obi_sbr.req;
    assign obi_sbr.rvalid = rvalid_q;
    assign obi_sbr.rdata  = rdata_q;

    // ip: SW write first, then ack clear, then the trigger condition ORs back in.
    always_comb begin
        logic [15:0] half_wdata;
        logic        sel, ctrl_be, prio_be, ip_sw, ack_clr, trig_set;
        half_wdata = '0;
        sel        = 1'b0;
        ctrl_be    = 1'b0;
        prio_be    = 1'b0;
        ip_sw      = 1'b0;
        ack_clr    = 1'b0;
        trig_set   = 1'b0;
        for (int unsigned i = 0; i < NrIrqLines; i++) begin
            sel        = wr_en && line_hit && (word_idx == 30'(i / 2));
            half_wdata = obi_sbr.wdata[16*(i%2) +: 16];
            ctrl_be    = obi_sbr.be[2*(i%2)];
            prio_be    = obi_sbr.be[2*(i%2)+1];
            line_d[i]  = line_q[i];
            ip_sw      = line_q[i].ip;
            if (sel && ctrl_be) begin
                line_d[i].ie   = half_wdata[IE_BIT];
                ip_sw          = half_wdata[IP_BIT];
                line_d[i].trig = trig_e'(half_wdata[TRIG_LSB +: 2]);
                line_d[i].heti = half_wdata[HETI_BIT];
                line_d[i].nest = half_wdata[NEST_BIT];
            end
            if (sel && prio_be) begin
                line_d[i].prio = half_wdata[PRIO_LSB +: PrioWidth];
            end
            ack_clr  = irq_ack_i && (irq_id_i == IrqWidth'(i)) && line_q[i].ip && line_q[i].ie;
            trig_set = 1'b0;
            case (line_q[i].trig)
                TRIG_LEVEL_HI: trig_set = irq_i[i];
                TRIG_RISE:     trig_set = irq_i[i] && !irq_q[i];
                TRIG_FALL:     trig_set = !irq_i[i] && irq_q[i];
                TRIG_LEVEL_LO: trig_set = !irq_i[i];
            endcase
            line_d[i].ip = trig_set | (ip_sw & ~ack_clr);
        end
    end

    always_comb begin
        thresh_d = thresh_q;
        if (wr_en && thresh_hit && obi_sbr.be[0]) begin
            thresh_d = obi_sbr.wdata[PrioWidth-1:0];
        end
    end

    always_comb begin
        rd_word = '0;
        if (thresh_hit) begin
            rd_word[PrioWidth-1:0] = thresh_q;
        end else if (line_hit) begin
            for (int unsigned w = 0; w < NrWords; w++) begin
                if (word_idx == 30'(w)) begin
                    rd_word = {pack_line(line_q[2*w+1]), pack_line(line_q[2*w])};
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NrIrqLines; i++) begin
                line_q[i] <= '0;
            end
            thresh_q <= '0;
            irq_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            line_q   <= line_d;
            thresh_q <= thresh_d;
            irq_q    <= irq_i;
            rvalid_q <= obi_sbr.req;
            rdata_q  <= rd_en ? rd_word : '0;
        end
    end

    always_comb begin
        cand_valid = '0;
        cand_prio  = '0;
        for (int unsigned i = 0; i < NrIrqLines; i++) begin
            cand_valid[i]                       = line_q[i].ie & line_q[i].ip;
            cand_prio[i*PrioWidth +: PrioWidth] = line_q[i].prio;
        end
    end

    hetic_arb_tree #(
        .NrIrqLines (NrIrqLines),
        .PrioWidth  (PrioWidth)
    ) u_arb_tree (
        .cand_valid (cand_valid),
        .cand_prio  (cand_prio),
        .win_valid  (win_valid),
        .win_prio   (win_prio),
        .win_id     (win_id)
    );

    // With no candidate only valid drops; the last winner's id/prio/heti/nest are held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_valid_o <= 1'b0;
            irq_heti_o  <= 1'b0;
            irq_nest_o  <= 1'b0;
            irq_id_o    <= '0;
            irq_prio_o  <= '0;
        end else if (win_valid) begin
            irq_valid_o <= (win_prio > thresh_q);
            irq_heti_o  <= line_q[win_id].heti;
            irq_nest_o  <= line_q[win_id].nest;
            irq_id_o    <= win_id;
            irq_prio_o  <= win_prio;
        end else begin
            irq_valid_o <= 1'b0;
        end
    end

endmodule
